// File: rtl/ser_pkg.sv
// ser_pkg: definitions shared by the serial transmitter and receiver.
//   ser_state_e        : frame sequencer states (unused encodings are treated as idle)
//   ParNone/ParEven/ParOdd : parity mode codes for the PARITY parameter
package ser_pkg;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StStart = 3'd1,
      StData  = 3'd2,
      StPar   = 3'd3,
      StStopb = 3'd4
   } ser_state_e;

   localparam int unsigned ParNone = 0;
   localparam int unsigned ParEven = 1;
   localparam int unsigned ParOdd  = 2;

endpackage

// File: rtl/ser_baud_div.sv
// ser_baud_div: bit-period counter for the serial link.
//   Counts 0..DIV-1 and asserts TICK combinationally on the last count of each bit period.
//   C    in  clock, state on posedge
//   RN   in  asynchronous active-low reset (counter to 0)
//   CLR  in  synchronous clear; restarts the bit period on the next edge
//   TICK out high during the final cycle of a bit period (every cycle when DIV=1)
module ser_baud_div #(
   parameter int unsigned DIV = 4
) (
   input  logic C,
   input  logic RN,
   input  logic CLR,
   output logic TICK
);

   localparam int unsigned     DivW    = $clog2(DIV + 1);
   localparam logic [DivW-1:0] DivLast = DivW'(DIV - 1);

   logic [DivW-1:0] div_q, div_d;

   assign TICK = (div_q == DivLast);

   always_comb begin
      div_d = div_q + 1'b1;
      if (CLR || TICK) begin
         div_d = '0;
      end
   end

   always_ff @(posedge C or negedge RN) begin
      if (!RN) begin
         div_q <= '0;
      end else begin
         div_q <= div_d;
      end
   end

endmodule

// File: rtl/ser_tx.sv
// ser_tx: parallel-to-serial transmitter, line idles high.
//   Frame: start bit (0), WIDTH data bits LSB first, optional parity bit, STOP stop bits (1);
//   every bit lasts DIV clock cycles.
//   C    in  clock, all state on posedge
//   RN   in  asynchronous active-low reset; drops any partial frame, Y returns high at once
//   D    in  word to send, sampled only on the acceptance edge
//   V    in  D valid
//   RDY  out ready, high only when idle; a word is taken on posedge C when V & RDY
//   Y    out registered serial line
//   BUSY out frame in progress
module ser_tx
   import ser_pkg::*;
#(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned DIV    = 4,
   parameter int unsigned STOP   = 1,
   parameter int unsigned PARITY = 0
) (
   input  logic             C,
   input  logic             RN,
   input  logic [WIDTH-1:0] D,
   input  logic             V,
   output logic             RDY,
   output logic             Y,
   output logic             BUSY
);

   localparam int unsigned      BitW     = $clog2(WIDTH + 1);
   localparam int unsigned      StopLen  = STOP * DIV;
   localparam int unsigned      StopW    = $clog2(StopLen + 1);
   localparam logic [BitW-1:0]  BitLast  = BitW'(WIDTH - 1);
   localparam logic [StopW-1:0] StopLast = StopW'(StopLen - 1);

   ser_state_e       state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [BitW-1:0]  bitcnt_q, bitcnt_d;
   logic [StopW-1:0] stopcnt_q, stopcnt_d;
   logic             par_q, par_d;
   logic             y_q, y_d;
   logic             tick;
   logic             accept;
   logic             div_clr;

   assign accept  = V & RDY;
   // Holding the divider clear while idle makes acceptance restart the bit period too.
   assign div_clr = (state_q == StIdle) || (state_d != state_q);

   ser_baud_div #(
      .DIV (DIV)
   ) u_baud_div (
      .C    (C),
      .RN   (RN),
      .CLR  (div_clr),
      .TICK (tick)
   );

   // State register
   always_ff @(posedge C or negedge RN) begin
      if (!RN) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (accept) state_d = StStart;
         end
         StStart: begin
            if (tick) state_d = StData;
         end
         StData: begin
            if (tick && (bitcnt_q == BitLast)) begin
               state_d = (PARITY != ParNone) ? StPar : StStopb;
            end
         end
         StPar: begin
            if (tick) state_d = StStopb;
         end
         StStopb: begin
            if (stopcnt_q == StopLast) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Output decode
   always_comb begin
      RDY  = (state_q == StIdle);
      BUSY = (state_q != StIdle);
      Y    = y_q;
   end

   // Datapath next-state: Y is computed one cycle ahead so it changes on the bit boundary edge.
   always_comb begin
      shift_d   = shift_q;
      bitcnt_d  = bitcnt_q;
      stopcnt_d = stopcnt_q;
      par_d     = par_q;
      y_d       = y_q;
      case (state_q)
         StIdle: begin
            y_d = 1'b1;
            if (accept) begin
               shift_d = D;
               par_d   = (PARITY == ParOdd) ? ~^D : ^D;
               y_d     = 1'b0;
            end
         end
         StStart: begin
            if (tick) y_d = shift_q[0];
         end
         StData: begin
            if (tick) begin
               shift_d = shift_q >> 1;
               if (bitcnt_q == BitLast) begin
                  bitcnt_d = '0;
                  y_d      = (PARITY != ParNone) ? par_q : 1'b1;
               end else begin
                  bitcnt_d = bitcnt_q + 1'b1;
                  y_d      = shift_d[0];
               end
            end
         end
         StPar: begin
            if (tick) y_d = 1'b1;
         end
         StStopb: begin
            y_d       = 1'b1;
            stopcnt_d = (stopcnt_q == StopLast) ? '0 : stopcnt_q + 1'b1;
         end
         default: begin
            y_d       = 1'b1;
            shift_d   = '0;
            bitcnt_d  = '0;
            stopcnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge C or negedge RN) begin
      if (!RN) begin
         shift_q   <= '0;
         bitcnt_q  <= '0;
         stopcnt_q <= '0;
         par_q     <= 1'b0;
         y_q       <= 1'b1;
      end else begin
         shift_q   <= shift_d;
         bitcnt_q  <= bitcnt_d;
         stopcnt_q <= stopcnt_d;
         par_q     <= par_d;
         y_q       <= y_d;
      end
   end

endmodule

// File: tb/tb_ser_tx.sv
// tb_ser_tx: self-checking bench for ser_tx.
//   Four instances share clock and reset: defaults, even parity, odd parity, and a minimal
//   DIV=1/WIDTH=1/STOP=2 build. Expected line waveforms come from a frame model built from
//   the frame definition (start, data LSB first, parity, stop bits, DIV cycles per bit).
module tb_ser_tx;

   logic        clk = 1'b0;
   logic        rn;
   logic [15:0] d [4];
   logic [3:0]  v;
   wire  [3:0]  rdy;
   wire  [3:0]  y;
   wire  [3:0]  busy;

   int cw    [4] = '{8, 8, 8, 1};
   int cdiv  [4] = '{4, 4, 4, 1};
   int cstop [4] = '{1, 1, 1, 2};
   int cpar  [4] = '{0, 1, 2, 0};

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   ser_tx u_def (
      .C(clk), .RN(rn), .D(d[0][7:0]), .V(v[0]), .RDY(rdy[0]), .Y(y[0]), .BUSY(busy[0])
   );

   ser_tx #(.WIDTH(8), .DIV(4), .STOP(1), .PARITY(1)) u_even (
      .C(clk), .RN(rn), .D(d[1][7:0]), .V(v[1]), .RDY(rdy[1]), .Y(y[1]), .BUSY(busy[1])
   );

   ser_tx #(.WIDTH(8), .DIV(4), .STOP(1), .PARITY(2)) u_odd (
      .C(clk), .RN(rn), .D(d[2][7:0]), .V(v[2]), .RDY(rdy[2]), .Y(y[2]), .BUSY(busy[2])
   );

   ser_tx #(.WIDTH(1), .DIV(1), .STOP(2), .PARITY(0)) u_small (
      .C(clk), .RN(rn), .D(d[3][0:0]), .V(v[3]), .RDY(rdy[3]), .Y(y[3]), .BUSY(busy[3])
   );

   // Frame model: value of bit slot idx of the frame carrying w on instance inst.
   function automatic logic frame_bit(input int inst, input logic [15:0] w, input int idx);
      logic p;
      p = 1'b0;
      if (idx == 0) return 1'b0;
      if (idx <= cw[inst]) return w[idx-1];
      if ((cpar[inst] != 0) && (idx == cw[inst] + 1)) begin
         for (int i = 0; i < cw[inst]; i++) p = p ^ w[i];
         return (cpar[inst] == 1) ? p : ~p;
      end
      return 1'b1;
   endfunction

   function automatic int frame_len(input int inst);
      return (1 + cw[inst] + ((cpar[inst] != 0) ? 1 : 0) + cstop[inst]) * cdiv[inst];
   endfunction

   // Send one word on an instance and check every cycle of the frame plus the return to idle.
   // With noise set, V and D are toggled randomly while the frame is in flight.
   task automatic send_and_check(input int inst, input logic [15:0] w, input bit noise,
                                 input string name);
      int f;
      int k;
      f = frame_len(inst);
      k = 0;
      while (rdy[inst] !== 1'b1 && k < 500) begin
         @(negedge clk);
         k++;
      end
      n_cmp++;
      if (rdy[inst] !== 1'b1) begin
         n_bad++;
         $display("FAIL %s ready_wait: rdy=%b required 1", name, rdy[inst]);
         return;
      end
      d[inst] = w;
      v[inst] = 1'b1;
      @(negedge clk);
      for (int c = 0; c < f; c++) begin
         v[inst] = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         d[inst] = 16'($urandom);
         n_cmp++;
         if ({y[inst], rdy[inst], busy[inst]} !== {frame_bit(inst, w, c / cdiv[inst]), 2'b01})
         begin
            n_bad++;
            $display("FAIL %s cycle %0d: y/rdy/busy=%b%b%b required %b01", name, c,
                     y[inst], rdy[inst], busy[inst], frame_bit(inst, w, c / cdiv[inst]));
         end
         @(negedge clk);
      end
      v[inst] = 1'b0;
      n_cmp++;
      if ({y[inst], rdy[inst], busy[inst]} !== 3'b110) begin
         n_bad++;
         $display("FAIL %s end: y/rdy/busy=%b%b%b required 110", name,
                  y[inst], rdy[inst], busy[inst]);
      end
   endtask

   task automatic test_reset();
      rn = 1'b1;
      #2 rn = 1'b0;
      #2;
      n_cmp++;
      if ({y, rdy, busy} !== 12'hFF0) begin
         n_bad++;
         $display("FAIL reset_init: y=%b rdy=%b busy=%b required 1111 1111 0000", y, rdy, busy);
      end
      @(negedge clk);
      rn = 1'b1;
      @(negedge clk);
      d[0] = 16'h00A5;
      v[0] = 1'b1;
      @(negedge clk);
      v[0] = 1'b0;
      @(negedge clk);
      // Mid start bit: line is low here, reset must raise it without a clock edge.
      v[0] = 1'b1;
      #2 rn = 1'b0;
      #1;
      n_cmp++;
      if ({y[0], rdy[0], busy[0]} !== 3'b110) begin
         n_bad++;
         $display("FAIL reset_async: y/rdy/busy=%b%b%b required 110", y[0], rdy[0], busy[0]);
      end
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({y[0], rdy[0], busy[0]} !== 3'b110) begin
         n_bad++;
         $display("FAIL reset_v_ignored: y/rdy/busy=%b%b%b required 110",
                  y[0], rdy[0], busy[0]);
      end
      v[0] = 1'b0;
      rn = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         n_cmp++;
         if ({y[0], rdy[0]} !== 2'b11) begin
            n_bad++;
            $display("FAIL idle_line cycle %0d: y/rdy=%b%b required 11", c, y[0], rdy[0]);
         end
      end
   endtask

   task automatic test_default_a5();
      send_and_check(0, 16'h00A5, 1'b0, "frame_a5");
   endtask

   task automatic test_parity();
      send_and_check(1, 16'h0007, 1'b0, "even_07");
      send_and_check(2, 16'h0007, 1'b0, "odd_07");
   endtask

   task automatic test_small();
      send_and_check(3, 16'h0001, 1'b0, "small_1");
      send_and_check(3, 16'h0000, 1'b0, "small_0");
   endtask

   task automatic test_random_frames();
      for (int inst = 0; inst < 4; inst++) begin
         for (int i = 0; i < 8; i++) begin
            send_and_check(inst, 16'($urandom), 1'b1, "random");
         end
      end
   endtask

   // V held high across two frames: the second word goes out after exactly one idle cycle.
   task automatic test_back_to_back();
      int   f;
      int   gap;
      int   c;
      logic ys [$];
      logic e;
      f = frame_len(0);
      @(negedge clk);
      d[0] = 16'h0000;
      v[0] = 1'b1;
      @(negedge clk);
      d[0] = 16'h00FF;
      for (int i = 0; i < 2 * f + 1; i++) begin
         ys.push_back(y[0]);
         if (i == f + 1) v[0] = 1'b0;
         @(negedge clk);
      end
      v[0] = 1'b0;
      for (int i = 0; i < 2 * f + 1; i++) begin
         if (i < f)       e = frame_bit(0, 16'h0000, i / cdiv[0]);
         else if (i == f) e = 1'b1;
         else             e = frame_bit(0, 16'h00FF, (i - f - 1) / cdiv[0]);
         n_cmp++;
         if (ys[i] !== e) begin
            n_bad++;
            $display("FAIL b2b cycle %0d: y=%b required %b", i, ys[i], e);
         end
      end
      gap = 0;
      c = f;
      while (c >= 0 && ys[c] === 1'b1) begin
         gap++;
         c--;
      end
      n_cmp++;
      if (gap != cstop[0] * cdiv[0] + 1) begin
         n_bad++;
         $display("FAIL b2b_gap: high cycles=%0d required %0d", gap, cstop[0] * cdiv[0] + 1);
      end
      n_cmp++;
      if ({rdy[0], y[0]} !== 2'b11) begin
         n_bad++;
         $display("FAIL b2b_end: rdy/y=%b%b required 11", rdy[0], y[0]);
      end
   endtask

   // Loopback: an independent receiver samples mid-bit and rebuilds each word.
   task automatic test_loopback();
      logic [7:0] sent [$];
      fork
         begin : tx
            int         k;
            logic [7:0] w;
            for (int i = 0; i < 256; i++) begin
               repeat ($urandom_range(0, 6)) @(negedge clk);
               k = 0;
               while (rdy[0] !== 1'b1 && k < 200) begin
                  @(negedge clk);
                  k++;
               end
               n_cmp++;
               if (rdy[0] !== 1'b1) begin
                  n_bad++;
                  $display("FAIL loop_tx_ready word %0d: rdy=%b required 1", i, rdy[0]);
                  break;
               end
               w = 8'($urandom);
               d[0] = {8'h00, w};
               sent.push_back(w);
               v[0] = 1'b1;
               @(negedge clk);
               v[0] = 1'b0;
               d[0] = 16'($urandom);
            end
         end
         begin : rx
            int         k;
            logic [7:0] got;
            logic [7:0] exp;
            logic       st;
            logic       sp;
            for (int i = 0; i < 256; i++) begin
               k = 0;
               while (y[0] !== 1'b0 && k < 1000) begin
                  @(negedge clk);
                  k++;
               end
               if (y[0] !== 1'b0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL loop_rx_start word %0d: y=%b required 0", i, y[0]);
                  break;
               end
               repeat (2) @(negedge clk);
               st = y[0];
               for (int b = 0; b < 8; b++) begin
                  repeat (4) @(negedge clk);
                  got[b] = y[0];
               end
               repeat (4) @(negedge clk);
               sp = y[0];
               exp = (sent.size() > 0) ? sent.pop_front() : ~got;
               n_cmp++;
               if ({st, got, sp} !== {1'b0, exp, 1'b1}) begin
                  n_bad++;
                  $display("FAIL loopback word %0d: start/data/stop=%b/%h/%b required 0/%h/1",
                           i, st, got, sp, exp);
               end
            end
         end
      join
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 4; i++) d[i] = 16'h0000;
      v = 4'b0000;
      test_reset();
      test_default_a5();
      test_parity();
      test_small();
      test_back_to_back();
      test_random_frames();
      test_loopback();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
